approx_mac_stream: RTL and testbench

- Parametrised successor of the fixed 8x8 approximate unsigned MAC.
- Streams operand pairs over a valid/ready interface and accumulates their products as a dot product, using a lower-part approximate adder.
- The approximation width is configurable; APPROX_BITS=0 gives exact accumulation.
- Returns one result per dot product (delimited by in_last) on a valid/ready output.
- Sits in the FunctionalUnits/macc library as the reusable accumulator for approximate-compute datapaths.

---
 rtl/approx_mac_pkg.sv | 34 +++
 rtl/approx_acc_add.sv | 29 ++
 rtl/approx_mac_stream.sv | 127 ++++++++++++
 tb/tb_approx_mac_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mac_pkg.sv
// Shared types and arithmetic for the approximate multiply-accumulate units.
// approx_add_f implements the lower-part approximate adder on a 64-bit carrier.
package approx_mac_pkg;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic {EMPTY, FULL} slot_e;

   function automatic int prod_w_f(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   // Result occupies [w-1:0]; bit MAX_W returns the carry out of the upper field.
   function automatic logic [MAX_W:0] approx_add_f(input word_t o, input word_t p,
                                                   input int k, input int w);
      logic [MAX_W:0] one, wm, km, um, oe, pe, up, lo, res;
      one = {{MAX_W{1'b0}}, 1'b1};
      wm  = (one << w) - one;
      km  = (one << k) - one;
      um  = wm & ~km;
      oe  = {1'b0, o};
      pe  = {1'b0, p};
      up  = (oe & um) + (pe & um);
      if (k > 0 && (((oe ^ pe) >> k) & one) != '0)
         lo = km;
      else
         lo = (oe + pe) & km;
      res = (up & wm) | lo;
      return {|(up & ~wm), res[MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/approx_acc_add.sv
// Combinational lower-part approximate adder, ACC_W wide with APPROX_BITS low bits approximate.
// With APPROX_MAC_SAT_EN defined the upper-field carry out is exposed for saturation.
module approx_acc_add
   import approx_mac_pkg::*;
#(
   parameter int ACC_W       = 20,
   parameter int APPROX_BITS = 3
) (
   input  logic [ACC_W-1:0] o,
   input  logic [ACC_W-1:0] p,
   output logic [ACC_W-1:0] sum
`ifdef APPROX_MAC_SAT_EN
   ,
   output logic             carry
`endif
);

   logic [MAX_W:0] r;
   logic           unused_r;

   assign r        = approx_add_f(word_t'(o), word_t'(p), APPROX_BITS, ACC_W);
   assign sum      = r[ACC_W-1:0];
   assign unused_r = ^r;

`ifdef APPROX_MAC_SAT_EN
   assign carry = r[MAX_W];
`endif

endmodule

// File: rtl/approx_mac_stream.sv
// Streaming approximate unsigned dot-product MAC: one result per in_last-delimited stream.
// Optional saturation and sticky out_ovf via APPROX_MAC_SAT_EN.
module approx_mac_stream
   import approx_mac_pkg::*;
#(
   parameter int A_W         = 8,
   parameter int B_W         = 8,
   parameter int ACC_W       = 20,
   parameter int APPROX_BITS = 3
) (
   input  logic             Clk,
   input  logic             aclr,
   input  logic             clken,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data
`ifdef APPROX_MAC_SAT_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int P_W = prod_w_f(A_W, B_W);

   typedef logic [P_W-1:0]   prod_t;
   typedef logic [ACC_W-1:0] acc_t;
   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic           last;
   } req_t;

   req_t  s1;
   logic  s1_vld;
   slot_e slot, slot_nxt;
   acc_t  acc, prod_ext, sum, nxt;
   prod_t prod;
   logic  accept, out_fire, s2_go, s2_load;

   // A last term parked in S1 blocks intake so its result always finds the slot free.
   assign out_valid = (slot == FULL);
   assign in_ready  = clken & ~(s1_vld & s1.last) & (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready & clken;
   assign s2_go     = clken & s1_vld;
   assign s2_load   = s2_go & s1.last;
   assign prod      = prod_t'(s1.a) * prod_t'(s1.b);
   assign prod_ext  = acc_t'(prod);

`ifdef APPROX_MAC_SAT_EN
   logic carry, acc_ovf, nxt_ovf;

   approx_acc_add #(.ACC_W(ACC_W), .APPROX_BITS(APPROX_BITS)) u_add (
      .o(acc), .p(prod_ext), .sum(sum), .carry(carry)
   );

   always_comb begin
      nxt_ovf = acc_ovf | carry;
      nxt     = nxt_ovf ? '1 : sum;
   end
`else
   approx_acc_add #(.ACC_W(ACC_W), .APPROX_BITS(APPROX_BITS)) u_add (
      .o(acc), .p(prod_ext), .sum(sum)
   );

   assign nxt = sum;
`endif

   always_ff @(posedge Clk or posedge aclr) begin
      if (aclr) begin
         s1     <= '0;
         s1_vld <= 1'b0;
      end else if (clken) begin
         s1_vld <= accept;
         if (accept) begin
            s1.a    <= in_a;
            s1.b    <= in_b;
            s1.last <= in_last;
         end
      end
   end

   always_ff @(posedge Clk or posedge aclr) begin
      if (aclr) begin
         acc      <= '0;
         out_data <= '0;
`ifdef APPROX_MAC_SAT_EN
         acc_ovf  <= 1'b0;
         out_ovf  <= 1'b0;
`endif
      end else if (s2_go) begin
         if (s1.last) begin
            acc      <= '0;
            out_data <= nxt;
`ifdef APPROX_MAC_SAT_EN
            acc_ovf  <= 1'b0;
            out_ovf  <= nxt_ovf;
`endif
         end else begin
            acc      <= nxt;
`ifdef APPROX_MAC_SAT_EN
            acc_ovf  <= nxt_ovf;
`endif
         end
      end
   end

   always_ff @(posedge Clk or posedge aclr) begin
      if (aclr) slot <= EMPTY;
      else      slot <= slot_nxt;
   end

   always_comb begin
      slot_nxt = slot;
      case (slot)
         EMPTY:   if (s2_load) slot_nxt = FULL;
         FULL:    if (out_fire && !s2_load) slot_nxt = EMPTY;
         default: slot_nxt = EMPTY;
      endcase
   end

endmodule

// File: tb/tb_approx_mac_stream.sv
// Bench for approx_mac_stream: three parameterisations share one stimulus stream and are
// checked every cycle against a field-arithmetic model; APPROX_MAC_SAT_EN selects saturation.
module tb_approx_mac_stream;

   localparam int NI = 3;

   logic Clk = 1'b0;
   logic aclr = 1'b1, clken = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [7:0] in_a = '0, in_b = '0;
   logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
   logic [19:0] od0, od1;
   logic [15:0] od2;
`ifdef APPROX_MAC_SAT_EN
   logic of0, of1, of2;
`endif

   int n_cmp = 0, n_bad = 0;
   bit chk_on = 0, rnd_rdy = 0;

   always #5 Clk = ~Clk;

   approx_mac_stream #(.APPROX_BITS(3)) u_dut (
      .Clk(Clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy0),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0)
`ifdef APPROX_MAC_SAT_EN
      , .out_ovf(of0)
`endif
   );

   approx_mac_stream #(.APPROX_BITS(0)) u_k0 (
      .Clk(Clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1)
`ifdef APPROX_MAC_SAT_EN
      , .out_ovf(of1)
`endif
   );

   approx_mac_stream #(.ACC_W(16), .APPROX_BITS(3)) u_w16 (
      .Clk(Clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy2),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2)
`ifdef APPROX_MAC_SAT_EN
      , .out_ovf(of2)
`endif
   );

   // ---------------- reference model ----------------
   int     kk[NI] = '{3, 0, 3};
   int     ww[NI] = '{20, 20, 16};
   longint m_acc[NI], m_res[NI], m_od[NI];
   bit     m_aov[NI], m_rov[NI], m_oov[NI];
   bit     m_ov = 0, m_pend = 0;
   logic   exp_rdy;

   assign exp_rdy = clken & ~m_pend & (~m_ov | out_ready);

   function automatic longint mdl_add(input longint o, input longint p, input int k,
                                      input int w, output bit c);
      longint bk, hi, lo, hm;
      bk = longint'(1) << k;
      hm = longint'(1) << (w - k);
      hi = o / bk + p / bk;
      c  = (hi >= hm);
      hi = hi % hm;
      if (k > 0 && ((o / bk) % 2) != ((p / bk) % 2)) lo = bk - 1;
      else lo = ((o % bk) + (p % bk)) % bk;
      return hi * bk + lo;
   endfunction

   always @(posedge Clk or posedge aclr) begin
      if (aclr) begin
         m_ov = 0; m_pend = 0;
         for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0; m_res[i] = 0; m_od[i] = 0;
            m_aov[i] = 0; m_rov[i] = 0; m_oov[i] = 0;
         end
      end else if (clken) begin
         bit fire, ofire, c;
         longint s;
         fire  = in_valid & exp_rdy;
         ofire = m_ov & out_ready;
         if (m_pend) begin
            m_ov = 1;
            for (int i = 0; i < NI; i++) begin m_od[i] = m_res[i]; m_oov[i] = m_rov[i]; end
         end else if (ofire) m_ov = 0;
         m_pend = fire & in_last;
         if (fire) begin
            for (int i = 0; i < NI; i++) begin
               s = mdl_add(m_acc[i], longint'(in_a) * longint'(in_b), kk[i], ww[i], c);
`ifdef APPROX_MAC_SAT_EN
               if (c || m_aov[i]) begin s = (longint'(1) << ww[i]) - 1; m_aov[i] = 1; end
`endif
               m_acc[i] = s;
               if (in_last) begin
                  m_res[i] = m_acc[i]; m_rov[i] = m_aov[i];
                  m_acc[i] = 0; m_aov[i] = 0;
               end
            end
         end
      end
   end

   function automatic void cmp(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge Clk) begin
      if (chk_on && !aclr) begin
         cmp("in_ready0", longint'(rdy0), longint'(exp_rdy));
         cmp("in_ready1", longint'(rdy1), longint'(exp_rdy));
         cmp("in_ready2", longint'(rdy2), longint'(exp_rdy));
         cmp("out_valid0", longint'(ov0), longint'(m_ov));
         cmp("out_valid1", longint'(ov1), longint'(m_ov));
         cmp("out_valid2", longint'(ov2), longint'(m_ov));
         if (m_ov) begin
            cmp("out_data0", longint'(od0), m_od[0]);
            cmp("out_data1", longint'(od1), m_od[1]);
            cmp("out_data2", longint'(od2), m_od[2]);
`ifdef APPROX_MAC_SAT_EN
            cmp("out_ovf0", longint'(of0), longint'(m_oov[0]));
            cmp("out_ovf1", longint'(of1), longint'(m_oov[1]));
            cmp("out_ovf2", longint'(of2), longint'(m_oov[2]));
`endif
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clk); #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int a, input int b, input bit last);
      @(negedge Clk); #1;
      in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b); in_last = last;
      for (int t = 0; ; t++) begin
         #1;
         if (rdy0) begin @(posedge Clk); break; end
         if (t > 300) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
            break;
         end
         @(negedge Clk); #1;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out();
      bit ok;
      ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge Clk);
         if (ov0) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL out_timeout: out_valid stayed 0, required 1");
      end
   endtask

   initial begin
      bit c;
      longint held, ex;
      #100000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit c;
      longint ex;
      // model pins
      cmp("mdl_15", mdl_add(0, 15, 3, 20, c), 15);
      cmp("mdl_23", mdl_add(15, 8, 3, 20, c), 23);
      cmp("mdl_8_15", mdl_add(0, 8, 3, 20, c), 15);
      cmp("mdl_fc02", mdl_add(64'hFE01, 64'hFE01, 3, 16, c), 64'hFC02);
      cmp("mdl_fc02_c", longint'(c), 1);
      cmp("mdl_exact", mdl_add(5, 7, 0, 20, c), 12);

      repeat (3) @(negedge Clk);
      cmp("rst_out_valid", longint'(ov0), 0);
      cmp("rst_out_data", longint'(od0), 0);
      #1 aclr = 1'b0;
      chk_on = 1;
      @(negedge Clk);
      cmp("rst_in_ready", longint'(rdy0), 1);

      // partial 15 then 23, two enabled edges after last accept
      send(3, 5, 0); send(2, 4, 1);
      @(negedge Clk);
      cmp("lat_early", longint'(ov0), 0);
      @(negedge Clk);
      cmp("lat_valid", longint'(ov0), 1);
      cmp("t1_d0", longint'(od0), 23);
      cmp("t1_d1", longint'(od1), 23);

      send(4, 2, 0); send(4, 2, 1); wait_out();
      cmp("t2_d0", longint'(od0), 23);
      cmp("t2_d1", longint'(od1), 16);

      send(6, 7, 1); wait_out();
      cmp("single_d0", longint'(od0), 47);
      cmp("single_d1", longint'(od1), 42);

      send(255, 255, 0); send(255, 255, 1); wait_out();
      cmp("sat_d0", longint'(od0), 20'h1FC02);
`ifdef APPROX_MAC_SAT_EN
      cmp("sat_d2", longint'(od2), 16'hFFFF);
      cmp("sat_ovf2", longint'(of2), 1);
      cmp("sat_ovf0", longint'(of0), 0);
`else
      cmp("wrap_d2", longint'(od2), 16'hFC02);
`endif

      // back-pressure: pending result blocks intake and holds out_data
      @(negedge Clk); #1 out_ready = 1'b0;
      send(1, 2, 1); wait_out();
      #1 in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
      repeat (5) begin
         @(negedge Clk); #2;
         cmp("hold_in_ready", longint'(rdy0), 0);
         cmp("hold_data", longint'(od0), 2);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge Clk); #1 out_ready = 1'b0;
      send(9, 9, 1); wait_out();
      cmp("after_hold_d0", longint'(od0), 81);
      #1 out_ready = 1'b1;

      // aclr mid-stream discards the partial sum
      send(3, 5, 0); send(2, 4, 0);
      @(negedge Clk); #1 aclr = 1'b1;
      @(negedge Clk); #1 aclr = 1'b0;
      @(negedge Clk);
      cmp("aclr_data", longint'(od0), 0);
      send(1, 1, 1); wait_out();
      cmp("aclr_d0", longint'(od0), 1);

      // clken freeze mid-stream
      send(3, 5, 0);
      @(negedge Clk); #1 clken = 1'b0;
      repeat (5) begin
         @(negedge Clk); #2;
         cmp("frz_in_ready", longint'(rdy0), 0);
      end
      clken = 1'b1;
      send(2, 4, 1); wait_out();
      cmp("frz_d0", longint'(od0), 23);

      // random streams, random back-pressure and gaps
      rnd_rdy = 1;
      for (int d = 0; d < 4; d++) begin
         longint ex_sum;
         ex_sum = 0;
         for (int t = 0; t < 64; t++) begin
            int a, b;
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            ex_sum += longint'(a) * longint'(b);
            send(a, b, t == 63);
            repeat ($urandom_range(0, 1)) @(negedge Clk);
         end
         wait_out();
`ifdef APPROX_MAC_SAT_EN
         ex = (ex_sum >= (longint'(1) << 20)) ? (longint'(1) << 20) - 1 : ex_sum;
`else
         ex = ex_sum % (longint'(1) << 20);
`endif
         cmp("rnd_exact_d1", longint'(od1), ex);
      end
      rnd_rdy = 0;
      @(negedge Clk); #1 out_ready = 1'b1;
      repeat (5) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
